ttc_int_ctrl1: RTL and testbench

- APB slave interrupt controller that sits directly downstream of the triple timer counter and consumes its interrupt[3:1] outputs.
- Per source it provides edge/level capture, a pending latch, a mask, overrun detection and a saturating event counter.
- It drives a single registered irq1 line to the CPU interrupt input.
- It shares the APB bus, pclk1 domain and 8-bit address space conventions with the timer block.

---
 rtl/ttc_int_ctrl1.sv | 153 +++++++++++++++
 tb/tb_ttc_int_ctrl1.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ttc_int_ctrl1.sv
// ttc_int_ctrl1: APB interrupt controller placed after the triple timer counter.
// Each source has edge or level capture, a pending latch, a mask, overrun
// detection and a saturating event counter. All sources are ORed into one
// registered irq1 line.
module ttc_int_ctrl1 #(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 8
) (
  input  logic               pclk1,
  input  logic               p_reset1,
  input  logic               psel1,
  input  logic               penable1,
  input  logic               pwrite1,
  input  logic [7:0]         paddr1,
  input  logic [31:0]        pwdata1,
  input  logic [NUM_SRC-1:0] int_in1,
  output logic [31:0]        prdata1,
  output logic               irq1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ovr_q, ovr_d;
  logic [NUM_SRC-1:0] int_prev_q;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic               irq_q, irq_d;

  logic               wr_s;
  logic [NUM_SRC-1:0] clr_s;
  logic               cnt_clr_s;
  logic [NUM_SRC-1:0] evt_s;
  logic [NUM_SRC-1:0] edge_evt_s;
  logic [31:0]        count_s;
  logic [31:0]        rdata_s;
  logic               unused_s;

  // Upper write-data bits have no storage behind them.
  assign unused_s = ^pwdata1[31:NUM_SRC];

  // Decode the APB write strobes used for the write-only clear registers.
  always_comb begin
    wr_s      = psel1 & penable1 & pwrite1;
    clr_s     = {NUM_SRC{1'b0}};
    cnt_clr_s = 1'b0;
    if (wr_s && (paddr1 == 8'h10)) begin
      clr_s = pwdata1[NUM_SRC-1:0];
    end else begin
      clr_s = {NUM_SRC{1'b0}};
    end
    if (wr_s && (paddr1 == 8'h1C)) begin
      cnt_clr_s = 1'b1;
    end else begin
      cnt_clr_s = 1'b0;
    end
  end

  // Event detection: rising edge, or input level when the MODE bit is set.
  always_comb begin
    edge_evt_s = ~mode_q & int_in1 & ~int_prev_q;
    evt_s      = (mode_q & int_in1) | edge_evt_s;
  end

  // Next state of the config registers, pending, overrun, counters and irq.
  always_comb begin
    mode_d = mode_q;
    mask_d = mask_q;
    if (wr_s && (paddr1 == 8'h00)) begin
      mode_d = pwdata1[NUM_SRC-1:0];
    end else begin
      mode_d = mode_q;
    end
    if (wr_s && (paddr1 == 8'h04)) begin
      mask_d = pwdata1[NUM_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    // A new event beats a clear in the same cycle.
    pend_d = evt_s | (pend_q & ~clr_s);
    // An edge that lands on an already pending bit that is not being cleared
    // counts as lost.
    ovr_d  = (ovr_q & ~clr_s) | (edge_evt_s & pend_q & ~clr_s);
    irq_d  = |(pend_q & mask_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cnt_clr_s) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (edge_evt_s[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers, all cleared asynchronously by p_reset1.
  always_ff @(posedge pclk1 or posedge p_reset1) begin
    if (p_reset1) begin
      mode_q     <= {NUM_SRC{1'b0}};
      mask_q     <= {NUM_SRC{1'b0}};
      pend_q     <= {NUM_SRC{1'b0}};
      ovr_q      <= {NUM_SRC{1'b0}};
      int_prev_q <= {NUM_SRC{1'b0}};
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      int_prev_q <= int_in1;
      irq_q      <= irq_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack the per-source counters into one 32-bit read word.
  always_comb begin
    count_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SRC; i++) begin
      count_s[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Combinational read mux. It drives zero outside a read and during reset.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!p_reset1 && psel1 && !pwrite1) begin
      case (paddr1)
        8'h00:   rdata_s = {{(32-NUM_SRC){1'b0}}, mode_q};
        8'h04:   rdata_s = {{(32-NUM_SRC){1'b0}}, mask_q};
        8'h08:   rdata_s = {{(32-NUM_SRC){1'b0}}, pend_q};
        8'h0C:   rdata_s = {{(32-NUM_SRC){1'b0}}, pend_q & mask_q};
        8'h14:   rdata_s = {{(32-NUM_SRC){1'b0}}, ovr_q};
        8'h18:   rdata_s = count_s;
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign prdata1 = rdata_s;
  assign irq1    = irq_q;

endmodule

// File: tb/tb_ttc_int_ctrl1.sv
// Directed bench for ttc_int_ctrl1. It applies a table of register accesses,
// then runs hand-written sequences for the multi-cycle interrupt behaviour.
module tb_ttc_int_ctrl1;

  logic        pclk1 = 1'b0;
  logic        p_reset1 = 1'b1;
  logic        psel1 = 1'b0;
  logic        penable1 = 1'b0;
  logic        pwrite1 = 1'b0;
  logic [7:0]  paddr1 = 8'h00;
  logic [31:0] pwdata1 = 32'h0;
  logic [2:0]  int_in1 = 3'b000;
  logic [31:0] prdata1;
  logic        irq1;

  int total = 0;
  int bad = 0;

  ttc_int_ctrl1 #(.NUM_SRC(3), .CNT_W(8)) dut (
    .pclk1(pclk1), .p_reset1(p_reset1), .psel1(psel1), .penable1(penable1),
    .pwrite1(pwrite1), .paddr1(paddr1), .pwdata1(pwdata1), .int_in1(int_in1),
    .prdata1(prdata1), .irq1(irq1)
  );

  always #5 pclk1 = ~pclk1;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;  // write data, or expected read value
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge pclk1); #1;
    psel1 = 1'b1; pwrite1 = 1'b1; penable1 = 1'b0; paddr1 = a; pwdata1 = d;
    @(posedge pclk1); #1;
    penable1 = 1'b1;
    @(posedge pclk1); #1;
    psel1 = 1'b0; penable1 = 1'b0; pwrite1 = 1'b0;
  endtask

  // Write whose access phase also raises int_in1 to ival, so the edge and
  // the write land on the same clock edge.
  task automatic apb_wr_int(input logic [7:0] a, input logic [31:0] d, input logic [2:0] ival);
    @(posedge pclk1); #1;
    psel1 = 1'b1; pwrite1 = 1'b1; penable1 = 1'b0; paddr1 = a; pwdata1 = d;
    @(posedge pclk1); #1;
    penable1 = 1'b1; int_in1 = ival;
    @(posedge pclk1); #1;
    psel1 = 1'b0; penable1 = 1'b0; pwrite1 = 1'b0; int_in1 = 3'b000;
  endtask

  task automatic apb_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    @(negedge pclk1);
    psel1 = 1'b1; pwrite1 = 1'b0; penable1 = 1'b0; paddr1 = a;
    #1;
    chk(name, prdata1, exp);
    psel1 = 1'b0;
  endtask

  task automatic pulse(input int idx);
    @(posedge pclk1); #1;
    int_in1[idx] = 1'b1;
    @(posedge pclk1); #1;
    int_in1[idx] = 1'b0;
  endtask

  initial begin
    // Register table: reset values, read-back widths, unmapped and WO reads.
    tbl[0]  = '{1'b0, 8'h00, 32'h0};
    tbl[1]  = '{1'b0, 8'h04, 32'h0};
    tbl[2]  = '{1'b0, 8'h08, 32'h0};
    tbl[3]  = '{1'b0, 8'h0C, 32'h0};
    tbl[4]  = '{1'b0, 8'h10, 32'h0};
    tbl[5]  = '{1'b0, 8'h14, 32'h0};
    tbl[6]  = '{1'b0, 8'h18, 32'h0};
    tbl[7]  = '{1'b0, 8'h1C, 32'h0};
    tbl[8]  = '{1'b1, 8'h04, 32'hFFFF_FFFF};
    tbl[9]  = '{1'b0, 8'h04, 32'h7};
    tbl[10] = '{1'b1, 8'h00, 32'h5};
    tbl[11] = '{1'b0, 8'h00, 32'h5};
    tbl[12] = '{1'b1, 8'h20, 32'hFFFF_FFFF};
    tbl[13] = '{1'b0, 8'h20, 32'h0};
    tbl[14] = '{1'b1, 8'h00, 32'h0};
    tbl[15] = '{1'b1, 8'h04, 32'h0};

    repeat (2) @(posedge pclk1);
    #1;
    chk("irq_in_reset", {31'b0, irq1}, 32'h0);
    p_reset1 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].addr, tbl[i].data);
      else apb_rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data);
    end
    chk("irq_after_reset", {31'b0, irq1}, 32'h0);

    // Single edge on source 2 with all sources enabled.
    apb_wr(8'h04, 32'h7);
    @(posedge pclk1); #1;
    int_in1[2] = 1'b1;
    @(posedge pclk1); #1;
    int_in1[2] = 1'b0;
    chk("irq_lat0", {31'b0, irq1}, 32'h0);
    apb_rd("raw_s2", 8'h08, 32'h4);
    @(posedge pclk1); #1;
    chk("irq_lat1", {31'b0, irq1}, 32'h1);
    apb_rd("status_s2", 8'h0C, 32'h4);
    apb_rd("count_s2", 8'h18, 32'h0001_0000);
    apb_wr(8'h10, 32'h4);
    chk("irq_clr_lag", {31'b0, irq1}, 32'h1);
    @(posedge pclk1); #1;
    chk("irq_clr", {31'b0, irq1}, 32'h0);
    apb_rd("raw_clr", 8'h08, 32'h0);

    // Three unmasked-off edges on source 0 set the overrun flag.
    apb_wr(8'h04, 32'h0);
    for (int i = 0; i < 3; i++) pulse(0);
    apb_rd("raw_ovr", 8'h08, 32'h1);
    apb_rd("ovr_s0", 8'h14, 32'h1);
    apb_rd("count_3", 8'h18, 32'h0001_0003);
    chk("irq_masked", {31'b0, irq1}, 32'h0);
    apb_wr(8'h04, 32'h1);
    chk("irq_mask_lag", {31'b0, irq1}, 32'h0);
    @(posedge pclk1); #1;
    chk("irq_mask_on", {31'b0, irq1}, 32'h1);
    apb_wr(8'h10, 32'h7);
    apb_rd("ovr_clr", 8'h14, 32'h0);

    // Edge in the same cycle as CLEAR of that bit: the set wins, no overrun.
    pulse(0);
    apb_wr_int(8'h10, 32'h1, 3'b001);
    apb_rd("raw_setwin", 8'h08, 32'h1);
    apb_rd("ovr_setwin", 8'h14, 32'h0);
    apb_rd("count_5", 8'h18, 32'h0001_0005);
    apb_wr(8'h10, 32'h7);

    // Level mode on source 1: a clear is ineffective while the input is high.
    apb_wr(8'h00, 32'h2);
    @(posedge pclk1); #1;
    int_in1[1] = 1'b1;
    apb_wr(8'h10, 32'h2);
    apb_rd("lvl_hold", 8'h08, 32'h2);
    int_in1[1] = 1'b0;
    @(posedge pclk1); #1;
    apb_wr(8'h10, 32'h2);
    apb_rd("lvl_clr", 8'h08, 32'h0);
    apb_rd("lvl_count", 8'h18, 32'h0001_0005);
    apb_rd("lvl_ovr", 8'h14, 32'h0);
    apb_wr(8'h00, 32'h0);

    // Counter saturation and counter clear.
    for (int i = 0; i < 300; i++) pulse(2);
    apb_rd("count_sat", 8'h18, 32'h00FF_0005);
    apb_wr(8'h1C, 32'h0);
    apb_rd("count_zero", 8'h18, 32'h0);

    // Reset during an active interrupt.
    apb_wr(8'h04, 32'h7);
    @(posedge pclk1); #1;
    chk("irq_pre_rst", {31'b0, irq1}, 32'h1);
    int_in1[2] = 1'b1;
    @(posedge pclk1);
    @(negedge pclk1);
    p_reset1 = 1'b1;
    #1;
    chk("irq_async_rst", {31'b0, irq1}, 32'h0);
    apb_rd("prdata_in_rst", 8'h08, 32'h0);
    p_reset1 = 1'b0;
    psel1 = 1'b1; pwrite1 = 1'b0; paddr1 = 8'h08;
    #1;
    chk("raw_after_rst", prdata1, 32'h0);
    psel1 = 1'b0;
    @(posedge pclk1); #1;
    // The input is still high and the previous-input register was cleared,
    // so one edge is seen after reset release.
    apb_rd("raw_post_rst", 8'h08, 32'h4);
    apb_rd("cnt_post_rst", 8'h18, 32'h0001_0000);
    apb_rd("mask_post_rst", 8'h04, 32'h0);
    int_in1 = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
